// File: rtl/stim_train_sequencer_if.sv
// Control/status bundle between a stimulation controller and the train sequencer.
// The controller side drives pattern config and plant flags; the sequencer drives keys and status.
interface stim_train_sequencer_if #(
    parameter int CNT_W = 24
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic             chan_sel;
    logic [CNT_W-1:0] pulse_int_us;
    logic [3:0]       burst_len;
    logic [CNT_W-1:0] burst_int_us;
    logic [CNT_W-1:0] train_len;
    logic [CNT_W-1:0] num_trains;
    logic [CNT_W-1:0] iti_us;
    logic             cap_ready;
    logic             scr_busy;
    logic             hw_fault;
    logic [1:0]       charge_key;
    logic [1:0]       fire_key;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output start, stop, mode, chan_sel, pulse_int_us, burst_len, burst_int_us,
               train_len, num_trains, iti_us, cap_ready, scr_busy, hw_fault,
        input  charge_key, fire_key, busy, done, cfg_err, fault, fault_code, pulse_cnt
    );

    modport slave (
        input  start, stop, mode, chan_sel, pulse_int_us, burst_len, burst_int_us,
               train_len, num_trains, iti_us, cap_ready, scr_busy, hw_fault,
        output charge_key, fire_key, busy, done, cfg_err, fault, fault_code, pulse_cnt
    );
endinterface

// File: rtl/stim_train_sequencer.sv
// Stimulation pattern sequencer: turns a latched single/rTMS/TBS pattern into
// 1-cycle charge/fire key requests paced on a 1 us timebase, gated on capacitor ready.
module stim_train_sequencer #(
    parameter int CLK_PER_US = 50,
    parameter int CNT_W      = 24,
    parameter int MIN_INT_US = 300
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    stim_train_sequencer_if.slave bus
);

    localparam int               PRE_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] MIN_INT = CNT_W'(MIN_INT_US);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_REP    = 2'b01;
    localparam logic [1:0] MODE_TBS    = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_LATE    = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;
    localparam logic [1:0] FC_HW      = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHARGE,
        S_ARM,
        S_DISCHG,
        S_FAULT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]       r_mode;
    logic             r_chan;
    logic [CNT_W-1:0] r_pulse_int;
    logic [3:0]       r_burst_len;
    logic [CNT_W-1:0] r_burst_int;
    logic [CNT_W-1:0] r_train_len;
    logic [CNT_W-1:0] r_num_trains;
    logic [CNT_W-1:0] r_iti;
    logic [CNT_W-1:0] r_next_int;

    logic [PRE_W-1:0] r_presc;
    logic [CNT_W-1:0] r_elapsed;
    logic [CNT_W-1:0] r_pulse_in_train;
    logic [3:0]       r_pulse_in_burst;
    logic [CNT_W-1:0] r_train_idx;
    logic             r_last;
    logic             r_seen_rise;

    logic [1:0]       r_charge_key;
    logic [1:0]       r_fire_key;
    logic             r_done;
    logic             r_cfg_err;
    logic [1:0]       r_fault_code;
    logic [CNT_W-1:0] r_pulse_cnt;

    logic             w_tick;
    logic             w_cfg_ok;
    logic             w_start_ok;
    logic             w_start_rej;
    logic             w_due;
    logic             w_fall;
    logic             w_timeout;
    logic             w_train_end;
    logic             w_burst_end;
    logic             w_last;
    logic [CNT_W-1:0] w_next_int;
    logic             w_charge_set;
    logic             w_fire_set;
    logic             w_done_set;
    logic [1:0]       w_fault_code_nxt;
    logic [1:0]       w_chan_mask;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    always_comb begin
        w_cfg_ok = 1'b1;
        if (bus.mode == MODE_RSVD)
            w_cfg_ok = 1'b0;
        if (bus.train_len == '0 || bus.num_trains == '0)
            w_cfg_ok = 1'b0;
        if ((bus.mode == MODE_REP || bus.mode == MODE_TBS) && bus.pulse_int_us < MIN_INT)
            w_cfg_ok = 1'b0;
        if (bus.mode == MODE_TBS && (bus.burst_len == 4'd0 || bus.burst_int_us < MIN_INT))
            w_cfg_ok = 1'b0;
        if (bus.num_trains > ONE && bus.iti_us < MIN_INT)
            w_cfg_ok = 1'b0;
    end

    assign w_start_ok  = (r_state == S_IDLE) && bus.start && !bus.stop && w_cfg_ok;
    assign w_start_rej = (r_state == S_IDLE) && bus.start && !bus.stop && !w_cfg_ok;

    // Timer is zero during the fire cycle, so firing on the cycle after
    // elapsed==next_int-1 at the last prescaler count gives exact next_int us spacing.
    assign w_tick    = (r_presc == PRE_MAX);
    assign w_timeout = (r_elapsed == r_next_int - ONE);
    assign w_due     = w_tick && w_timeout;
    assign w_fall    = r_seen_rise && !bus.scr_busy;

    assign w_train_end = (r_pulse_in_train + ONE == r_train_len);
    assign w_burst_end = (r_mode == MODE_TBS) && (r_pulse_in_burst + 4'd1 == r_burst_len);
    assign w_last      = (r_mode == MODE_SINGLE) ||
                         (w_train_end && (r_train_idx + ONE == r_num_trains));

    always_comb begin
        w_next_int = r_pulse_int;
        if (w_train_end || r_mode == MODE_SINGLE)
            w_next_int = r_iti;
        else if (w_burst_end)
            w_next_int = r_burst_int;
    end

    assign w_chan_mask = (r_state == S_IDLE) ? (bus.chan_sel ? 2'b10 : 2'b01)
                                             : (r_chan ? 2'b10 : 2'b01);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // hw_fault outranks stop, which outranks the per-state late/timeout checks.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (w_start_ok)
                w_state_nxt = S_CHARGE;
        end else if (bus.hw_fault) begin
            w_state_nxt = S_FAULT;
        end else if (bus.stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_CHARGE: if (bus.cap_ready) w_state_nxt = S_DISCHG;
                S_ARM:    if (w_due) w_state_nxt = bus.cap_ready ? S_DISCHG : S_FAULT;
                S_DISCHG: begin
                    if (w_fall)
                        w_state_nxt = r_last ? S_IDLE : S_ARM;
                    else if (w_timeout)
                        w_state_nxt = S_FAULT;
                end
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_charge_set     = 1'b0;
        w_fire_set       = 1'b0;
        w_done_set       = 1'b0;
        w_fault_code_nxt = r_fault_code;
        if (r_state == S_IDLE) begin
            w_charge_set = w_start_ok;
        end else if (bus.hw_fault) begin
            w_fault_code_nxt = FC_HW;
        end else if (bus.stop) begin
            w_fault_code_nxt = FC_NONE;
        end else begin
            case (r_state)
                S_CHARGE: w_fire_set = bus.cap_ready;
                S_ARM: begin
                    if (w_due) begin
                        if (bus.cap_ready)
                            w_fire_set = 1'b1;
                        else
                            w_fault_code_nxt = FC_LATE;
                    end
                end
                S_DISCHG: begin
                    if (w_fall) begin
                        if (r_last)
                            w_done_set = 1'b1;
                        else
                            w_charge_set = 1'b1;
                    end else if (w_timeout) begin
                        w_fault_code_nxt = FC_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_charge_key <= 2'b00;
            r_fire_key   <= 2'b00;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_fault_code <= FC_NONE;
            r_pulse_cnt  <= '0;
        end else begin
            r_charge_key <= w_charge_set ? w_chan_mask : 2'b00;
            r_fire_key   <= w_fire_set ? w_chan_mask : 2'b00;
            r_done       <= w_done_set;
            r_cfg_err    <= w_start_rej;
            r_fault_code <= w_fault_code_nxt;
            if (w_start_ok)
                r_pulse_cnt <= '0;
            else if (w_fire_set)
                r_pulse_cnt <= sat_inc(r_pulse_cnt);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_presc   <= '0;
            r_elapsed <= '0;
        end else if (w_fire_set) begin
            r_presc   <= '0;
            r_elapsed <= '0;
        end else if (w_tick) begin
            r_presc   <= '0;
            r_elapsed <= r_elapsed + ONE;
        end else begin
            r_presc   <= r_presc + PRE_W'(1);
        end
    end

    // Burst position restarts with every train, so a train may end mid-burst.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pulse_in_train <= '0;
            r_pulse_in_burst <= 4'd0;
            r_train_idx      <= '0;
            r_last           <= 1'b0;
            r_seen_rise      <= 1'b0;
        end else if (w_start_ok) begin
            r_pulse_in_train <= '0;
            r_pulse_in_burst <= 4'd0;
            r_train_idx      <= '0;
            r_last           <= 1'b0;
            r_seen_rise      <= 1'b0;
        end else if (w_fire_set) begin
            r_last      <= w_last;
            r_seen_rise <= 1'b0;
            if (w_train_end) begin
                r_pulse_in_train <= '0;
                r_pulse_in_burst <= 4'd0;
                r_train_idx      <= r_train_idx + ONE;
            end else begin
                r_pulse_in_train <= r_pulse_in_train + ONE;
                r_pulse_in_burst <= w_burst_end ? 4'd0 : r_pulse_in_burst + 4'd1;
            end
        end else if (r_state == S_DISCHG && bus.scr_busy) begin
            r_seen_rise <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_start_ok) begin
            r_mode       <= bus.mode;
            r_chan       <= bus.chan_sel;
            r_pulse_int  <= bus.pulse_int_us;
            r_burst_len  <= bus.burst_len;
            r_burst_int  <= bus.burst_int_us;
            r_train_len  <= bus.train_len;
            r_num_trains <= bus.num_trains;
            r_iti        <= bus.iti_us;
        end
        if (w_fire_set)
            r_next_int <= w_next_int;
    end

    assign bus.charge_key = r_charge_key;
    assign bus.fire_key   = r_fire_key;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.fault      = (r_state == S_FAULT);
    assign bus.fault_code = r_fault_code;
    assign bus.pulse_cnt  = r_pulse_cnt;

endmodule

// File: tb/tb_stim_train_sequencer.sv
// Directed bench for stim_train_sequencer: start-validation table plus hand sequences
// for pacing, TBS bursts, late/hw faults, stop and mid-session reset.
module tb_stim_train_sequencer;
    localparam int CPU = 4;
    localparam int CW  = 16;
    localparam int MIN = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stim_train_sequencer_if #(.CNT_W(CW)) bus();

    stim_train_sequencer #(
        .CLK_PER_US(CPU),
        .CNT_W     (CW),
        .MIN_INT_US(MIN)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [1:0] mode;
        int         pint;
        int         blen;
        int         bint;
        int         tlen;
        int         ntr;
        int         iti;
        bit         err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_fire, n_charge, n_done, done_t;
    logic [1:0] fire_bits, charge_bits;
    int         fire_t[$];
    int         cap_t = 0;
    int         scr_t = 0;
    int         cap_delay = 8;
    int         cap_max = 1000;
    int         clr_req = 0;
    int         clr_seen = 0;

    // Plant model: cap charges cap_delay cycles after a charge key, SCR window opens
    // two cycles after a fire and lasts six cycles.
    always @(negedge clk) begin
        if (clr_req != clr_seen) begin
            clr_seen    = clr_req;
            n_fire      = 0;
            n_charge    = 0;
            n_done      = 0;
            done_t      = 0;
            fire_bits   = 2'b00;
            charge_bits = 2'b00;
            fire_t.delete();
        end
        if (bus.fire_key != 2'b00) begin
            fire_t.push_back(cyc);
            n_fire++;
            fire_bits     = fire_bits | bus.fire_key;
            bus.cap_ready = 1'b0;
            scr_t         = 1;
        end else if (scr_t != 0) begin
            scr_t++;
            if (scr_t > 8) scr_t = 0;
        end
        bus.scr_busy = (scr_t >= 3);
        if (bus.charge_key != 2'b00) begin
            n_charge++;
            charge_bits = charge_bits | bus.charge_key;
            cap_t       = cap_delay;
        end else if (cap_t > 0) begin
            cap_t--;
            if (cap_t == 0) bus.cap_ready = (n_charge <= cap_max);
        end
        if (bus.done) begin
            n_done++;
            done_t = cyc;
        end
        if (!bus.busy) begin
            bus.cap_ready = 1'b0;
            cap_t         = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        clr_req++;
        tick();
    endtask

    task automatic start_sess(input logic [1:0] m, input logic ch, input int pint, input int blen,
                              input int bint, input int tlen, input int ntr, input int iti);
        bus.mode         = m;
        bus.chan_sel     = ch;
        bus.pulse_int_us = CW'(pint);
        bus.burst_len    = 4'(blen);
        bus.burst_int_us = CW'(bint);
        bus.train_len    = CW'(tlen);
        bus.num_trains   = CW'(ntr);
        bus.iti_us       = CW'(iti);
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
    endtask

    task automatic wait_fires(input int n, input int bound, input string name);
        int k = 0;
        while (n_fire < n && k < bound) begin
            tick();
            k++;
        end
        if (n_fire < n) check(name, n_fire, n);
    endtask

    task automatic wait_done(input int bound, input string name);
        int k = 0;
        while (n_done < 1 && k < bound) begin
            tick();
            k++;
        end
        if (n_done < 1) check(name, n_done, 1);
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    vec_t vt[12];
    int   exp_rep[5];
    int   exp_tbs[5];
    int   fault_cyc;

    initial begin
        vt[0]  = '{2'b11, 12, 3, 25, 1, 1, 0,  1'b1};
        vt[1]  = '{2'b01, 5,  0, 0,  1, 1, 0,  1'b1};
        vt[2]  = '{2'b01, 12, 0, 0,  0, 1, 0,  1'b1};
        vt[3]  = '{2'b01, 12, 0, 0,  1, 0, 0,  1'b1};
        vt[4]  = '{2'b10, 12, 0, 25, 3, 1, 0,  1'b1};
        vt[5]  = '{2'b10, 12, 3, 5,  3, 1, 0,  1'b1};
        vt[6]  = '{2'b01, 12, 0, 0,  1, 2, 9,  1'b1};
        vt[7]  = '{2'b01, 10, 0, 0,  1, 2, 10, 1'b0};
        vt[8]  = '{2'b00, 5,  0, 0,  1, 1, 0,  1'b0};
        vt[9]  = '{2'b00, 12, 0, 0,  1, 2, 5,  1'b1};
        vt[10] = '{2'b10, 10, 3, 10, 3, 1, 0,  1'b0};
        vt[11] = '{2'b01, 9,  0, 0,  1, 1, 0,  1'b1};
        exp_rep = '{48, 48, 120, 48, 48};
        exp_tbs = '{40, 40, 100, 40, 40};

        bus.start = 1'b0; bus.stop = 1'b0; bus.hw_fault = 1'b0;
        bus.mode = 2'b00; bus.chan_sel = 1'b0; bus.pulse_int_us = '0; bus.burst_len = 4'd0;
        bus.burst_int_us = '0; bus.train_len = '0; bus.num_trains = '0; bus.iti_us = '0;

        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_charge", bus.charge_key, 0);
        check("rst_fire", bus.fire_key, 0);
        check("rst_done", bus.done, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_code", bus.fault_code, 0);
        check("rst_pulse_cnt", bus.pulse_cnt, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            start_sess(vt[i].mode, 1'b0, vt[i].pint, vt[i].blen, vt[i].bint,
                       vt[i].tlen, vt[i].ntr, vt[i].iti);
            check($sformatf("vec%0d_cfg_err", i), bus.cfg_err, int'(vt[i].err));
            check($sformatf("vec%0d_busy", i), bus.busy, int'(!vt[i].err));
            check($sformatf("vec%0d_charge", i), bus.charge_key, vt[i].err ? 0 : 1);
            tick();
            check($sformatf("vec%0d_cfg_err_1cyc", i), bus.cfg_err, 0);
            if (!vt[i].err) begin
                pulse_stop();
                check($sformatf("vec%0d_stop_idle", i), bus.busy, 0);
            end
            tick();
        end

        bus.stop = 1'b1;
        start_sess(2'b01, 1'b0, 12, 0, 0, 3, 1, 0);
        bus.stop = 1'b0;
        check("start_stop_busy", bus.busy, 0);
        check("start_stop_cfg_err", bus.cfg_err, 0);
        check("start_stop_charge", bus.charge_key, 0);
        tick();

        clear_mon();
        start_sess(2'b00, 1'b0, 0, 0, 0, 1, 1, 40);
        wait_done(300, "single_done_wait");
        check("single_busy_after_done", bus.busy, 0);
        if (fire_t.size() > 0) check("single_done_after_fall", done_t - fire_t[0], 9);
        repeat (3) tick();
        check("single_n_charge", n_charge, 1);
        check("single_n_fire", n_fire, 1);
        check("single_charge_bits", charge_bits, 1);
        check("single_fire_bits", fire_bits, 1);
        check("single_n_done", n_done, 1);
        check("single_pulse_cnt", bus.pulse_cnt, 1);

        clear_mon();
        start_sess(2'b01, 1'b0, 12, 0, 0, 3, 2, 30);
        bus.pulse_int_us = CW'(20);
        wait_done(2000, "rep_done_wait");
        repeat (3) tick();
        check("rep_n_fire", n_fire, 6);
        check("rep_n_charge", n_charge, 6);
        check("rep_pulse_cnt", bus.pulse_cnt, 6);
        check("rep_n_done", n_done, 1);
        if (fire_t.size() == 6)
            for (int i = 0; i < 5; i++)
                check($sformatf("rep_spacing%0d", i), fire_t[i+1] - fire_t[i], exp_rep[i]);

        clear_mon();
        start_sess(2'b10, 1'b1, 10, 3, 25, 6, 1, 40);
        wait_done(2000, "tbs_done_wait");
        repeat (3) tick();
        check("tbs_n_fire", n_fire, 6);
        check("tbs_fire_bits", fire_bits, 2);
        check("tbs_charge_bits", charge_bits, 2);
        check("tbs_pulse_cnt", bus.pulse_cnt, 6);
        check("tbs_n_done", n_done, 1);
        if (fire_t.size() == 6)
            for (int i = 0; i < 5; i++)
                check($sformatf("tbs_spacing%0d", i), fire_t[i+1] - fire_t[i], exp_tbs[i]);

        clear_mon();
        cap_max = 1;
        start_sess(2'b01, 1'b0, 12, 0, 0, 5, 1, 40);
        begin
            int k = 0;
            while (!bus.fault && k < 300) begin
                tick();
                k++;
            end
        end
        fault_cyc = cyc;
        check("late_fault", bus.fault, 1);
        check("late_code", bus.fault_code, 1);
        if (fire_t.size() > 0) check("late_fault_time", fault_cyc - fire_t[0], 48);
        check("late_n_fire", n_fire, 1);
        check("late_n_charge", n_charge, 2);
        pulse_stop();
        check("late_stop_busy", bus.busy, 0);
        check("late_stop_fault", bus.fault, 0);
        check("late_stop_code", bus.fault_code, 0);
        cap_max = 1000;
        tick();

        clear_mon();
        start_sess(2'b01, 1'b0, 12, 0, 0, 5, 1, 40);
        begin
            int k = 0;
            while (n_charge < 2 && k < 200) begin
                tick();
                k++;
            end
            if (n_charge < 2) check("hw_arm_wait", n_charge, 2);
        end
        repeat (3) tick();
        bus.hw_fault = 1'b1;
        bus.stop     = 1'b1;
        tick();
        bus.hw_fault = 1'b0;
        bus.stop     = 1'b0;
        check("hw_fault", bus.fault, 1);
        check("hw_code", bus.fault_code, 3);
        check("hw_busy", bus.busy, 1);
        repeat (80) tick();
        check("hw_n_fire", n_fire, 1);
        check("hw_n_charge", n_charge, 2);
        pulse_stop();
        check("hw_stop_busy", bus.busy, 0);
        check("hw_stop_fault", bus.fault, 0);
        check("hw_stop_code", bus.fault_code, 0);
        check("hw_n_done", n_done, 0);

        clear_mon();
        start_sess(2'b01, 1'b0, 12, 0, 0, 5, 1, 40);
        wait_fires(1, 100, "dis_fire_wait");
        pulse_stop();
        check("dis_stop_busy", bus.busy, 0);
        repeat (60) tick();
        check("dis_n_charge", n_charge, 1);
        check("dis_n_fire", n_fire, 1);
        check("dis_n_done", n_done, 0);
        check("dis_pulse_cnt", bus.pulse_cnt, 1);

        clear_mon();
        start_sess(2'b01, 1'b1, 12, 0, 0, 5, 1, 40);
        wait_fires(1, 100, "mrst_fire_wait");
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("mrst_busy", bus.busy, 0);
        check("mrst_pulse_cnt", bus.pulse_cnt, 0);
        check("mrst_fault", bus.fault, 0);
        check("mrst_charge", bus.charge_key, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
